pipelined_dadda_multiplier: RTL and testbench

PIPELINED_DADDA_MULTIPLIER -- requirements
Module: pipelined_dadda_multiplier

---
 rtl/pipelined_dadda_multiplier.sv | 180 ++++++++++++++++++
 tb/tb_pipelined_dadda_multiplier.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipelined_dadda_multiplier.sv
// pipelined_dadda_multiplier
//   Three-stage signed/unsigned multiplier with valid/ready handshakes.
//   S1 registers the operands, S2 registers the two rows left by a Dadda
//   tree, and S3 registers the carry-select (BEC) sum into p.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake for a, b, is_signed, in_tag
//   out_valid/out_ready   output handshake for p, out_tag
//   busy                  any stage holds a valid operation
module pipelined_dadda_multiplier #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);
    localparam int N  = 2 * WIDTH;
    localparam int MH = WIDTH + 2;   // column height bound incl. constants
    localparam int DSEQ [8] = '{2, 3, 4, 6, 9, 13, 19, 28};

    // stage registers
    logic             s1_v, s2_v, s3_v;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic             s1_sgn;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic [N-1:0]     s2_r0, s2_r1;

    // a stage loads when it is empty or its content leaves this cycle
    logic s1_adv, s2_adv, s3_adv;
    assign s3_adv    = !s3_v || out_ready;
    assign s2_adv    = !s2_v || s3_adv;
    assign s1_adv    = !s1_v || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s3_v;
    assign busy      = s1_v | s2_v | s3_v;

    // Partial products + Dadda reduction. Each column is a bit vector with
    // a fill count; new bits are OR-ed in at position cnt via a shift.
    logic [MH-1:0] col  [N];
    logic [MH-1:0] ncol [N];
    int            cnt  [N];
    int            ncnt [N];
    logic [N-1:0]  row0, row1;

    always_comb begin
        logic          bit_v, x, y, z;
        logic [MH-1:0] sh;
        int            idx, rem, tot, d;
        bit_v = 1'b0; x = 1'b0; y = 1'b0; z = 1'b0; sh = '0;
        idx = 0; rem = 0; tot = 0; d = 0;
        for (int c = 0; c < N; c++) begin
            col[c] = '0; cnt[c] = 0; ncol[c] = '0; ncnt[c] = 0;
        end
        // Baugh-Wooley: invert MSB row/column terms except the corner
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                bit_v = s1_a[j] & s1_b[i];
                if (s1_sgn && ((i == WIDTH-1) != (j == WIDTH-1)))
                    bit_v = ~bit_v;
                col[i+j] = col[i+j] | (MH'(bit_v) << cnt[i+j]);
                cnt[i+j] = cnt[i+j] + 1;
            end
        end
        if (s1_sgn) begin
            col[WIDTH] = col[WIDTH] | (MH'(1'b1) << cnt[WIDTH]);
            cnt[WIDTH] = cnt[WIDTH] + 1;
            col[N-1]   = col[N-1] | (MH'(1'b1) << cnt[N-1]);
            cnt[N-1]   = cnt[N-1] + 1;
        end
        // Stages whose target is at or above the current height are no-ops,
        // so running the whole sequence caps it below WIDTH automatically.
        for (int s = 7; s >= 0; s--) begin
            d = DSEQ[s];
            for (int c = 0; c < N; c++) begin
                ncol[c] = '0; ncnt[c] = 0;
            end
            for (int c = 0; c < N; c++) begin
                idx = 0;
                // ncnt[c] already counts carries arriving from column c-1
                for (int k = 0; k < MH; k++) begin
                    rem = cnt[c] - idx;
                    tot = rem + ncnt[c];
                    if (tot > d && rem >= 2) begin
                        sh = col[c] >> idx;
                        x = sh[0]; y = sh[1]; z = sh[2];
                        if (tot == d + 1 || rem < 3) begin
                            idx = idx + 2;            // half adder
                            z   = 1'b0;
                        end else begin
                            idx = idx + 3;            // full adder
                        end
                        ncol[c] = ncol[c] | (MH'(x ^ y ^ z) << ncnt[c]);
                        ncnt[c] = ncnt[c] + 1;
                        if (c + 1 < N) begin
                            ncol[c+1] = ncol[c+1] | (MH'((x & y) | (z & (x ^ y))) << ncnt[c+1]);
                            ncnt[c+1] = ncnt[c+1] + 1;
                        end
                    end
                end
                // untouched bits pass straight through
                sh = col[c] >> idx;
                for (int k = 0; k < MH; k++) begin
                    if (k < cnt[c] - idx) begin
                        ncol[c] = ncol[c] | (MH'(sh[0]) << ncnt[c]);
                        ncnt[c] = ncnt[c] + 1;
                        sh = sh >> 1;
                    end
                end
            end
            for (int c = 0; c < N; c++) begin
                col[c] = ncol[c]; cnt[c] = ncnt[c];
            end
        end
        for (int c = 0; c < N; c++) begin
            row0[c] = col[c][0];
            row1[c] = col[c][1];
        end
    end

    // Carry-select final adder: upper half precomputed as h and h+1 (BEC)
    logic [WIDTH:0]   lo;
    logic [WIDTH-1:0] hi, hi_p1;
    logic [N-1:0]     sum;
    always_comb begin
        logic t;
        lo = {1'b0, s2_r0[WIDTH-1:0]} + {1'b0, s2_r1[WIDTH-1:0]};
        hi = s2_r0[N-1:WIDTH] + s2_r1[N-1:WIDTH];
        t  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            hi_p1[i] = hi[i] ^ t;
            t        = t & hi[i];
        end
        sum = {(lo[WIDTH] ? hi_p1 : hi), lo[WIDTH-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0; s2_v <= 1'b0; s3_v <= 1'b0;
            s1_a <= '0; s1_b <= '0; s1_sgn <= 1'b0; s1_tag <= '0;
            s2_r0 <= '0; s2_r1 <= '0; s2_tag <= '0;
            p <= '0; out_tag <= '0;
        end else begin
            if (s3_adv) begin
                s3_v <= s2_v;
                if (s2_v) begin
                    p       <= sum;
                    out_tag <= s2_tag;
                end
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_r0  <= row0;
                    s2_r1  <= row1;
                    s2_tag <= s1_tag;
                end
            end
            if (s1_adv) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_a   <= a;
                    s1_b   <= b;
                    s1_sgn <= is_signed;
                    s1_tag <= in_tag;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_dadda_multiplier.sv
// Self-checking bench for pipelined_dadda_multiplier (WIDTH=8, TAG_W=4).
// Inputs are driven on the falling edge; outputs are checked 1ns later.
module tb_pipelined_dadda_multiplier;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, is_signed, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] p;

    pipelined_dadda_multiplier #(.WIDTH(8), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .p(p),
        .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] p; logic [3:0] tag; } exp_t;
    typedef struct { logic [7:0] a, b; logic s; logic [3:0] tag; logic [15:0] p; } vec_t;

    exp_t q[$];
    int   n_checks = 0, n_fail = 0, n_out = 0, n_in = 0;

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
        int sx, sy, pr;
        sx = s ? int'($signed(x)) : int'(x);
        sy = s ? int'($signed(y)) : int'(y);
        pr = sx * sy;
        return pr[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, check against the model, record transfers, wait.
    task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                        input logic is, input logic [3:0] it, input logic ordy);
        in_valid = iv; a = ia; b = ib; is_signed = is; in_tag = it; out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!(q.size() == 3 && !ordy)));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 32'(0));
            end else begin
                chk("p", 32'(p), 32'(q[0].p));
                chk("out_tag", 32'(out_tag), 32'(q[0].tag));
                if (ordy) begin
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end
        if (iv && in_ready) begin
            q.push_back('{p: ref_mul(ia, ib, is), tag: it});
            n_in++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, ordy);
    endtask

    vec_t tbl[10];

    initial begin
        int lat, cyc, outs0;
        tbl[0] = '{a: 8'hFF, b: 8'hFF, s: 1'b0, tag: 4'h3, p: 16'hFE01};
        tbl[1] = '{a: 8'h80, b: 8'h80, s: 1'b1, tag: 4'h1, p: 16'h4000};
        tbl[2] = '{a: 8'hFF, b: 8'h01, s: 1'b1, tag: 4'h2, p: 16'hFFFF};
        tbl[3] = '{a: 8'hFF, b: 8'h01, s: 1'b0, tag: 4'h4, p: 16'h00FF};
        tbl[4] = '{a: 8'h7F, b: 8'h7F, s: 1'b1, tag: 4'h5, p: 16'h3F01};
        tbl[5] = '{a: 8'h80, b: 8'h7F, s: 1'b1, tag: 4'h6, p: 16'hC080};
        tbl[6] = '{a: 8'h00, b: 8'h80, s: 1'b1, tag: 4'h7, p: 16'h0000};
        tbl[7] = '{a: 8'h80, b: 8'hFF, s: 1'b1, tag: 4'h8, p: 16'h0080};
        tbl[8] = '{a: 8'hFF, b: 8'hFF, s: 1'b1, tag: 4'hF, p: 16'h0001};
        tbl[9] = '{a: 8'h80, b: 8'h80, s: 1'b0, tag: 4'h0, p: 16'h4000};

        // reset state
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        in_tag = '0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_p", 32'(p), 32'(0));
        chk("rst_out_tag", 32'(out_tag), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        rst_n = 1'b1;

        // directed vectors with latency check
        foreach (tbl[i]) begin
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].tag, 1'b1);
            lat = 1;
            while (!out_valid && lat < 8) begin
                idle(1'b1);
                lat++;
            end
            chk("latency", 32'(lat), 32'(3));
            chk("tbl_p", 32'(p), 32'(tbl[i].p));
            chk("tbl_tag", 32'(out_tag), 32'(tbl[i].tag));
            idle(1'b1);
        end

        // backpressure: 5 ops with out_ready=0, then release
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'(8'h11 * (i + 1)), 8'(8'h23 + i), 1'(i % 2), 4'(i + 9), 1'b0);
        chk("bp_accepted", 32'(q.size()), 32'(3));
        chk("bp_in_ready_low", 32'(in_ready), 32'(0));
        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            if (n_in < 45) step(1'b1, 8'h5A, 8'hC3, 1'b1, 4'hC, 1'b1);
            else idle(1'b1);
            cyc++;
        end
        chk("bp_drained", 32'(q.size()), 32'(0));

        // full-rate stream
        outs0 = n_out;
        for (int i = 0; i < 100; i++)
            step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 1'b1);
        chk("fullrate_outputs", 32'(n_out - outs0), 32'(97));
        chk("fullrate_occupancy", 32'(q.size()), 32'(3));
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin idle(1'b1); cyc++; end

        // reset with two operations in flight
        step(1'b1, 8'h12, 8'h34, 1'b0, 4'hA, 1'b0);
        step(1'b1, 8'h56, 8'h78, 1'b1, 4'hB, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(1));
        chk("midrst_p", 32'(p), 32'(0));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) idle(1'b1);

        // random traffic with random backpressure
        n_in = 0; cyc = 0;
        while (n_in < 1000 && cyc < 20000) begin
            step(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
            cyc++;
        end
        chk("random_accepted", 32'(n_in), 32'(1000));
        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin idle(1'b1); cyc++; end
        chk("final_drain", 32'(q.size()), 32'(0));
        chk("final_busy", 32'(busy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
